// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO and its storage.
package fifo_pkg;

    // Default data word width.
    localparam int unsigned DEF_DATA_W   = 8;
    // Default memory address width.
    localparam int unsigned DEF_ADDR_W   = 5;
    // Default number of storage words.
    localparam int unsigned DEF_DEPTH    = 2 ** DEF_ADDR_W;
    // Default almost-full threshold (count >= level).
    localparam int unsigned DEF_AF_LEVEL = 28;
    // Default almost-empty threshold (count <= level).
    localparam int unsigned DEF_AE_LEVEL = 4;

    // Pointer/count width: one extra bit so that a completely full FIFO (count == depth)
    // is representable and the pointer MSB can serve as a wrap bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram_32x8.sv
// Simple dual-port storage array: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old contents.
module sdp_ram_32x8
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rd_data_q;

    // Write port: store the word on an enabled edge; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: register the addressed word every cycle (old data on a collision).
    always_ff @(posedge i_clk) begin
        rd_data_q <= mem_q[i_rd_addr];
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: owns the pointers, occupancy count, status flags and the
// read-valid pipeline bit, and drives a simple dual-port memory for the data itself.
// All status flags are registered from the next-state count, so accept decisions always
// use the flags of the current cycle.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_almost_full,
    output logic              o_almost_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = cnt_width(DEPTH);

    localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] CNT_AF   = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] CNT_AE   = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);

    // Flag values for an empty FIFO, used on reset.
    localparam logic AF_AT_ZERO = (AF_LEVEL == 0);
    localparam logic AE_AT_ZERO = 1'b1;

    // Pointers carry a wrap bit above the memory address bits.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;

    logic full_q, empty_q, af_q, ae_q;
    logic rd_valid_q;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic wr_acc, rd_acc;
    logic wr_rej, rd_rej;

    // Accept/reject decisions and next-state pointers, count and sticky errors.
    always_comb begin
        wr_acc = i_wr_en && !full_q;
        rd_acc = i_rd_en && !empty_q;
        wr_rej = i_wr_en && full_q;
        rd_rej = i_rd_en && empty_q;

        wr_ptr_d = wr_acc ? wr_ptr_q + CNT_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + CNT_ONE : rd_ptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (wr_rej) begin
            ovf_d = 1'b1;
        end else if (i_clr_err) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (rd_rej) begin
            unf_d = 1'b1;
        end else if (i_clr_err) begin
            unf_d = 1'b0;
        end
    end

    // State registers: pointers, count, registered flags, read-valid pulse and errors.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= AF_AT_ZERO;
            ae_q       <= AE_AT_ZERO;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= CNT_AF);
            ae_q       <= (count_d <= CNT_AE);
            rd_valid_q <= rd_acc;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // The read address follows rd_ptr every cycle; the RAM output register is o_rd_data,
    // so data for a read accepted on an edge appears alongside rd_valid_q.
    sdp_ram_32x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .i_rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .i_wr_data (i_wr_data),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid     = rd_valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a queue-based reference model compared on every
// falling edge, directed scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo_ctrl;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AF    = 28;
    localparam int unsigned AE    = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_rd_en = 1'b0;
    logic       i_clr_err = 1'b0;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_full;
    logic       o_empty;
    logic       o_almost_full;
    logic       o_almost_empty;
    logic [5:0] o_count;
    logic       o_overflow;
    logic       o_underflow;

    always #5 i_clk = ~i_clk;

    sync_fifo_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .i_rd_en        (i_rd_en),
        .i_clr_err      (i_clr_err),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a queue plus the visible pulse/sticky state.
    logic [7:0] m_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    always @(posedge i_clk) begin
        automatic int  sz    = m_q.size();
        automatic bit  full  = (sz == DEPTH);
        automatic bit  empty = (sz == 0);
        if (i_rst) begin
            m_q.delete();
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else begin
            if (i_rd_en && !empty) m_data <= m_q.pop_front();
            m_valid <= i_rd_en && !empty;
            if (i_wr_en && !full) m_q.push_back(i_wr_data);
            if (i_wr_en && full) m_ovf <= 1'b1;
            else if (i_clr_err) m_ovf <= 1'b0;
            if (i_rd_en && empty) m_unf <= 1'b1;
            else if (i_clr_err) m_unf <= 1'b0;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("count", o_count, m_q.size());
            check("empty", o_empty, m_q.size() == 0);
            check("full", o_full, m_q.size() == DEPTH);
            check("almost_full", o_almost_full, m_q.size() >= AF);
            check("almost_empty", o_almost_empty, m_q.size() <= AE);
            check("rd_valid", o_rd_valid, m_valid);
            check("overflow", o_overflow, m_ovf);
            check("underflow", o_underflow, m_unf);
            if (m_valid) check("rd_data", o_rd_data, m_data);
        end
    end

    // One clock of stimulus; outputs are settled when it returns.
    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        i_clr_err = clr;
        @(posedge i_clk);
        #2;
        i_wr_en   = 1'b0;
        i_rd_en   = 1'b0;
        i_clr_err = 1'b0;
    endtask

    initial begin
        int pw [6] = '{80, 30, 50, 95, 20, 60};
        int pr [6] = '{30, 80, 50, 95, 20, 40};

        // Reset and idle.
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #2;
        i_rst  = 1'b0;
        chk_en = 1'b1;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_count", o_count, 0);
        check("idle_empty", o_empty, 1);
        check("idle_ae", o_almost_empty, 1);
        check("idle_full", o_full, 0);
        check("idle_valid", o_rd_valid, 0);
        check("idle_ovf", o_overflow, 0);
        check("idle_unf", o_underflow, 0);

        // Five writes then five back-to-back reads.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
        check("w5_count", o_count, 5);
        check("w5_ae", o_almost_empty, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("r5_valid", o_rd_valid, 1);
            check("r5_data", o_rd_data, i + 1);
            check("r5_count", o_count, 4 - i);
            check("r5_ae", o_almost_empty, 1);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("r5_valid_end", o_rd_valid, 0);

        // Fill to full, overflow, clear, simultaneous at full, read out.
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            check("fill_af", o_almost_full, (i + 1) >= 28);
        end
        check("full_count", o_count, 32);
        check("full_flag", o_full, 1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", o_overflow, 1);
        check("ovf_count", o_count, 32);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", o_overflow, 0);
        cyc(1'b1, 8'hBB, 1'b1, 1'b0);
        check("simfull_count", o_count, 31);
        check("simfull_ovf", o_overflow, 1);
        check("simfull_valid", o_rd_valid, 1);
        check("simfull_data", o_rd_data, 8'h00);
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            check("drain_data", o_rd_data, i);
        end
        check("drain_empty", o_empty, 1);

        // Simultaneous at empty; clear racing a new underflow.
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        check("simempty_count", o_count, 1);
        check("simempty_unf", o_underflow, 1);
        check("simempty_valid", o_rd_valid, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("simempty_data", o_rd_data, 8'h77);
        check("unf_clr", o_underflow, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("unf_set_wins", o_underflow, 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr2", o_underflow, 0);

        // Constant occupancy of 3 across pointer wrap.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(8'h13 + i), 1'b1, 1'b0);
            check("wrap_count", o_count, 3);
            check("wrap_data", o_rd_data, 8'(8'h10 + i));
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset with data queued and a read in flight.
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_valid", o_rd_valid, 1);
        i_rst = 1'b1;
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        i_rst = 1'b0;
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_valid", o_rd_valid, 0);
        check("rst_unf", o_underflow, 0);
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("post_rst_data", o_rd_data, 8'h5A);
        check("post_rst_valid", o_rd_valid, 1);

        // Randomized traffic with varying write/read pressure.
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 400; k++) begin
                i_rst = ($urandom_range(299) == 0);
                cyc(($urandom_range(99) < pw[b]), 8'($urandom), ($urandom_range(99) < pr[b]),
                    ($urandom_range(19) == 0));
                i_rst = 1'b0;
            end
        end

        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Synchronous FIFO built around a simple dual-port memory: one write port, one registered read port, depth 32 × 8 bits by default.
- Owns the write/read pointers, the occupancy count and the status flags. It drives the memory's write address, read address, write enable and write data.
- Sits between a byte producer (e.g. a UART RX or packet source) and its consumer, and decouples their rates.

Parameters:
- DATA_W, 8, data word width.
- ADDR_W, 5, memory address width; DEPTH = 2**ADDR_W = 32.
- AF_LEVEL, 28, o_almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, o_almost_empty asserts when count <= AE_LEVEL.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wr_en  in  1  write request.
- i_wr_data  in  DATA_W  write data.
- i_rd_en  in  1  read request.
- i_clr_err  in  1  clears the sticky error flags.
- o_rd_data  out  DATA_W  read data; meaningful only while o_rd_valid = 1.
- o_rd_valid  out  1  one-cycle pulse, 1 clock after an accepted read.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AF_LEVEL.
- o_almost_empty  out  1  count <= AE_LEVEL.
- o_count  out  ADDR_W+1  occupancy, range 0..32.
- o_overflow  out  1  sticky: a write was attempted while full.
- o_underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0; o_rd_valid, o_overflow and o_underflow go to 0.
  - After reset: o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0.
  - Memory contents are not cleared. o_rd_data is undefined until the first o_rd_valid.
  - Reset mid-stream discards all queued data and any read in flight; o_rd_valid is 0 in the cycle after reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide. The low ADDR_W bits address the memory; the MSB is a wrap bit.
  - Pointers increment modulo 2**(ADDR_W+1), so 63 -> 0.
- Accept rules (all flags are registered, so decisions use current-cycle state):
  - Write accepted = i_wr_en && !o_full. The memory is written at wr_ptr[ADDR_W-1:0] on that edge, and wr_ptr increments.
  - Read accepted = i_rd_en && !o_empty. rd_ptr[ADDR_W-1:0] is the memory read address on that edge, and rd_ptr increments.
  - The memory read address is driven by rd_ptr every cycle; the memory's output register is o_rd_data.
- Read latency: 1 clock. An accepted read at edge N gives o_rd_valid = 1 and the data on o_rd_data during cycle N+1.
- Count:
  - +1 for a write alone, -1 for a read alone, unchanged for both or neither.
  - All flags are derived from the next count and registered, so they are valid in the same cycle as the count.
- Simultaneous write and read:
  - Not full and not empty: both accepted, count unchanged.
  - Empty: write accepted, read rejected, o_underflow set; count becomes 1.
  - Full: read accepted, write rejected, o_overflow set; count becomes 31.
  - No same-cycle bypass: a word written at edge N is first readable by a read accepted at edge N+1, with data out in cycle N+2.
- Wrap-around: after 32 writes and 32 reads, both pointers equal 32 (MSB 1, low bits 0). count is 0 and o_empty = 1.
- Error flags:
  - Set on rejected requests; hold until i_clr_err or i_rst.
  - If i_clr_err coincides with a new error in the same cycle, the set wins.
  - Rejected requests have no other effect.

Decomposition:
- Shared package fifo_pkg holds DATA_W, ADDR_W and DEPTH defaults, plus the count/pointer width function clog2(DEPTH)+1.
- One sub-module, sdp_ram_32x8: the storage array.
  - Ports: clock, write enable, write address, read address, write data, registered read data.
  - A same-address read and write returns the old data.
- The controller holds pointers, count, flags and the valid pipeline bit only.

Test Plan:
- Reset, then idle 3 cycles -> o_empty = 1, o_count = 0, o_rd_valid = 0, no error flags.
- Write 0x01..0x05, then read 5 times back-to-back -> o_rd_valid pulses on 5 consecutive cycles with data 0x01..0x05; o_count goes 5 -> 0; o_almost_empty rises when count reaches 4.
- Write 0x00..0x1F (32 words) -> o_full = 1, o_count = 32, o_almost_full from count 28. A 33rd write of 0xAA is rejected and sets o_overflow; a full read-out returns 0x00..0x1F with no 0xAA.
- Wrap test: 40 interleaved write/read pairs at a constant occupancy of 3 -> data order preserved across pointer wrap; o_count stays 3.
- Simultaneous i_wr_en and i_rd_en:
  - While empty: count 0 -> 1, o_underflow set, no o_rd_valid.
  - While full: count 32 -> 31, o_overflow set, the read returns the oldest word.
- Assert i_rst with 10 words queued and a read in flight -> next cycle o_count = 0, o_empty = 1, o_rd_valid = 0, flags cleared. A subsequent write/read of 0x5A returns 0x5A.
